// File: rtl/alu_exec_unit_pkg.sv
// Shared widths, bus types and opcode encodings for the ALU execution unit
// and anything that drives or observes it.
package alu_exec_unit_pkg;

   localparam int DATA_BITS  = 32;
   localparam int TAG_BITS   = 4;
   localparam int OP_BITS    = 6;
   localparam int BTAG_BITS  = 4;

   typedef logic [DATA_BITS-1:0] DataBus;
   typedef logic [TAG_BITS-1:0]  TagBus;
   typedef logic [OP_BITS-1:0]   OpBus;
   typedef logic [BTAG_BITS-1:0] BranchTagBus;

   // A zero tag means "no producer", so it is never a valid destination.
   localparam TagBus tagFree = '0;

   localparam OpBus OP_NOP   = 6'd0;
   localparam OpBus OP_ADD   = 6'd1;
   localparam OpBus OP_SUB   = 6'd2;
   localparam OpBus OP_SLL   = 6'd3;
   localparam OpBus OP_SRL   = 6'd4;
   localparam OpBus OP_SRA   = 6'd5;
   localparam OpBus OP_SLT   = 6'd6;
   localparam OpBus OP_SLTU  = 6'd7;
   localparam OpBus OP_XOR   = 6'd8;
   localparam OpBus OP_OR    = 6'd9;
   localparam OpBus OP_AND   = 6'd10;
   localparam OpBus OP_LUI   = 6'd11;
   localparam OpBus OP_AUIPC = 6'd12;
   localparam OpBus OP_JAL   = 6'd13;
   localparam OpBus OP_JALR  = 6'd14;

endpackage

// File: rtl/alu_exec_unit_core.sv
// Purely combinational integer datapath: (op, O, T, PC) -> result, plus a
// flag telling the caller whether the opcode produces anything at all.
module alu_core
   import alu_exec_unit_pkg::*;
#(
   parameter int DATA_W = DATA_BITS,
   parameter int OP_W   = OP_BITS
) (
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] opO,
   input  logic [DATA_W-1:0] opT,
   input  logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] result,
   output logic              hasResult
);

   localparam int SHAMT_W = $clog2(DATA_W);

   OpBus               opc;
   logic [SHAMT_W-1:0] shamt;

   assign opc   = OpBus'(op);
   assign shamt = opT[SHAMT_W-1:0];

   // NOP and any unlisted encoding fall into the default arm and report no result.
   always_comb begin
      result    = '0;
      hasResult = 1'b1;
      case (opc)
         OP_ADD:   result = opO + opT;
         OP_SUB:   result = opO - opT;
         OP_SLL:   result = opO << shamt;
         OP_SRL:   result = opO >> shamt;
         OP_SRA:   result = $unsigned($signed(opO) >>> shamt);
         OP_SLT:   result = DATA_W'($signed(opO) < $signed(opT));
         OP_SLTU:  result = DATA_W'(opO < opT);
         OP_XOR:   result = opO ^ opT;
         OP_OR:    result = opO | opT;
         OP_AND:   result = opO & opT;
         OP_LUI:   result = opT;
         OP_AUIPC: result = pc + opT;
         OP_JAL,
         OP_JALR:  result = pc + DATA_W'(4);
         default:  hasResult = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution end: computes the issued op, holds it in a one-entry result
// register and broadcasts it on the write-back bus under cdbGrant.
module alu_exec_unit
   import alu_exec_unit_pkg::*;
#(
   parameter int DATA_W = DATA_BITS,
   parameter int TAG_W  = TAG_BITS,
   parameter int OP_W   = OP_BITS,
   parameter int BTAG_W = BTAG_BITS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issueEn,
   input  logic [DATA_W-1:0] issueOpO,
   input  logic [DATA_W-1:0] issueOpT,
   input  logic [OP_W-1:0]   issueOp,
   input  logic [TAG_W-1:0]  issueTagW,
   input  logic [DATA_W-1:0] issuePC,
   input  logic [BTAG_W-1:0] issueBTag,
   input  logic              cdbGrant,
   input  logic              bFreeEn,
   input  logic [1:0]        bFreeNum,
   input  logic              misTaken,
   output logic              aluBusy,
   output logic              wbEn,
   output logic [TAG_W-1:0]  wbTag,
   output logic [DATA_W-1:0] wbData,
   output logic [BTAG_W-1:0] wbBTag,
   output logic              protErr
);

   logic              rValid;
   logic [TAG_W-1:0]  rTag;
   logic [DATA_W-1:0] rData;
   logic [BTAG_W-1:0] rBTag;
   logic              rProtErr;

   logic              nValid;
   logic [TAG_W-1:0]  nTag;
   logic [DATA_W-1:0] nData;
   logic [BTAG_W-1:0] nBTag;
   logic              nProtErr;

   logic [DATA_W-1:0] coreResult;
   logic              coreHasResult;

   logic              branchKill;
   logic              branchResolve;
   logic [BTAG_W-1:0] clearMask;
   logic [BTAG_W-1:0] heldBTag;
   logic [BTAG_W-1:0] incomingBTag;
   logic              heldKilled;
   logic              incomingKilled;
   logic              slotOpen;

   alu_core #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
   ) uCore (
      .op        (issueOp),
      .opO       (issueOpO),
      .opT       (issueOpT),
      .pc        (issuePC),
      .result    (coreResult),
      .hasResult (coreHasResult)
   );

   assign branchKill     = bFreeEn & misTaken;
   assign branchResolve  = bFreeEn & ~misTaken;
   assign clearMask      = BTAG_W'(1) << bFreeNum;
   assign heldKilled     = branchKill & rBTag[bFreeNum];
   assign incomingKilled = branchKill & issueBTag[bFreeNum];
   assign heldBTag       = branchResolve ? (rBTag & ~clearMask) : rBTag;
   assign incomingBTag   = branchResolve ? (issueBTag & ~clearMask) : issueBTag;
   assign slotOpen       = ~rValid | cdbGrant;

   // A grant drains the entry; a new op refills it in the same cycle so
   // back-to-back results go out without a bubble. Killed entries drop out
   // on this edge even if they were granted, the ROB filters by tag.
   always_comb begin
      nValid   = rValid & ~cdbGrant & ~heldKilled;
      nTag     = rTag;
      nData    = rData;
      nBTag    = heldBTag;
      nProtErr = rProtErr | (issueEn & rValid & ~cdbGrant);
      if (issueEn & slotOpen & coreHasResult & ~incomingKilled) begin
         nValid = 1'b1;
         nTag   = issueTagW;
         nData  = coreResult;
         nBTag  = incomingBTag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rValid   <= 1'b0;
         rTag     <= TAG_W'(tagFree);
         rData    <= '0;
         rBTag    <= '0;
         rProtErr <= 1'b0;
      end else begin
         rValid   <= nValid;
         rTag     <= nTag;
         rData    <= nData;
         rBTag    <= nBTag;
         rProtErr <= nProtErr;
      end
   end

   assign aluBusy = rValid & ~cdbGrant;
   assign wbEn    = rValid;
   assign wbTag   = rTag;
   assign wbData  = rData;
   assign wbBTag  = rBTag;
   assign protErr = rProtErr;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: arithmetic results, hold/grant handshake,
// branch kill/resolve, protocol error and back-to-back streaming.
module tb_alu_exec_unit;
   import alu_exec_unit_pkg::*;

   logic        clk;
   logic        rst;
   logic        issueEn;
   DataBus      issueOpO;
   DataBus      issueOpT;
   OpBus        issueOp;
   TagBus       issueTagW;
   DataBus      issuePC;
   BranchTagBus issueBTag;
   logic        cdbGrant;
   logic        bFreeEn;
   logic [1:0]  bFreeNum;
   logic        misTaken;
   logic        aluBusy;
   logic        wbEn;
   TagBus       wbTag;
   DataBus      wbData;
   BranchTagBus wbBTag;
   logic        protErr;

   int compareCount = 0;
   int mismatchCount = 0;

   alu_exec_unit dut (
      .clk       (clk),
      .rst       (rst),
      .issueEn   (issueEn),
      .issueOpO  (issueOpO),
      .issueOpT  (issueOpT),
      .issueOp   (issueOp),
      .issueTagW (issueTagW),
      .issuePC   (issuePC),
      .issueBTag (issueBTag),
      .cdbGrant  (cdbGrant),
      .bFreeEn   (bFreeEn),
      .bFreeNum  (bFreeNum),
      .misTaken  (misTaken),
      .aluBusy   (aluBusy),
      .wbEn      (wbEn),
      .wbTag     (wbTag),
      .wbData    (wbData),
      .wbBTag    (wbBTag),
      .protErr   (protErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled 1ns after the rising edge, once the register has settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input OpBus op, input DataBus o, input DataBus t,
                                input TagBus tag, input DataBus pc, input BranchTagBus btag,
                                input logic grant);
      issueEn   = en;
      issueOp   = op;
      issueOpO  = o;
      issueOpT  = t;
      issueTagW = tag;
      issuePC   = pc;
      issueBTag = btag;
      cdbGrant  = grant;
   endtask

   task automatic setBranch(input logic en, input logic mis, input logic [1:0] num);
      bFreeEn  = en;
      misTaken = mis;
      bFreeNum = num;
   endtask

   task automatic idle(input logic grant);
      applyStimulus(1'b0, OP_NOP, '0, '0, '0, '0, '0, grant);
   endtask

   // Issues one op with the bus always granting and checks its result a cycle later.
   task automatic issueAndCheck(input string name, input OpBus op, input DataBus o, input DataBus t,
                                input DataBus pc, input DataBus expected);
      applyStimulus(1'b1, op, o, t, 4'd2, pc, '0, 1'b1);
      tick();
      idle(1'b1);
      checkOutput({name, "_en"}, 32'(wbEn), 32'd1);
      checkOutput(name, wbData, expected);
   endtask

   initial begin
      rst = 1'b1;
      idle(1'b0);
      setBranch(1'b0, 1'b0, 2'd0);
      tick();
      tick();
      rst = 1'b0;
      checkOutput("rst_wbEn", 32'(wbEn), 32'd0);
      checkOutput("rst_wbTag", 32'(wbTag), 32'd0);
      checkOutput("rst_wbData", wbData, 32'd0);
      checkOutput("rst_wbBTag", 32'(wbBTag), 32'd0);
      checkOutput("rst_protErr", 32'(protErr), 32'd0);
      checkOutput("rst_busy", 32'(aluBusy), 32'd0);

      // ADD wraps around to zero
      applyStimulus(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd1, 4'd5, '0, '0, 1'b1);
      tick();
      idle(1'b1);
      checkOutput("add_wbEn", 32'(wbEn), 32'd1);
      checkOutput("add_wbTag", 32'(wbTag), 32'd5);
      checkOutput("add_wbData", wbData, 32'd0);
      tick();
      checkOutput("add_drain", 32'(wbEn), 32'd0);

      issueAndCheck("sra",   OP_SRA,   32'h8000_0000, 32'h24, '0, 32'hF800_0000);
      issueAndCheck("sltu",  OP_SLTU,  32'd1, 32'hFFFF_FFFF, '0, 32'd1);
      issueAndCheck("jal",   OP_JAL,   32'd7, 32'd9, 32'h100, 32'h104);
      issueAndCheck("sub",   OP_SUB,   32'd5, 32'd7, '0, 32'hFFFF_FFFE);
      issueAndCheck("sll",   OP_SLL,   32'd1, 32'h21, '0, 32'd2);
      issueAndCheck("srl",   OP_SRL,   32'h8000_0000, 32'd4, '0, 32'h0800_0000);
      issueAndCheck("slt",   OP_SLT,   32'hFFFF_FFFF, 32'd1, '0, 32'd1);
      issueAndCheck("sltu0", OP_SLTU,  32'hFFFF_FFFF, 32'd1, '0, 32'd0);
      issueAndCheck("xor",   OP_XOR,   32'hF0F0, 32'hFF00, '0, 32'h0FF0);
      issueAndCheck("or",    OP_OR,    32'hF0F0, 32'hFF00, '0, 32'hFFF0);
      issueAndCheck("and",   OP_AND,   32'hF0F0, 32'hFF00, '0, 32'hF000);
      issueAndCheck("lui",   OP_LUI,   32'd3, 32'h1234_5000, '0, 32'h1234_5000);
      issueAndCheck("auipc", OP_AUIPC, 32'd3, 32'h20, 32'h1000, 32'h1020);
      issueAndCheck("jalr",  OP_JALR,  32'h40, 32'd0, 32'h200, 32'h204);
      tick();

      // A NOP never produces a result
      applyStimulus(1'b1, OP_NOP, 32'd1, 32'd1, 4'd9, '0, '0, 1'b1);
      tick();
      idle(1'b1);
      checkOutput("nop_wbEn", 32'(wbEn), 32'd0);

      // Held result with no grant stays stable; grant plus a new issue replaces it
      applyStimulus(1'b1, OP_ADD, 32'd2, 32'd3, 4'd3, '0, '0, 1'b0);
      tick();
      idle(1'b0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("hold_busy", 32'(aluBusy), 32'd1);
         checkOutput("hold_wbEn", 32'(wbEn), 32'd1);
         checkOutput("hold_wbTag", 32'(wbTag), 32'd3);
         checkOutput("hold_wbData", wbData, 32'd5);
         tick();
      end
      applyStimulus(1'b1, OP_ADD, 32'd10, 32'd1, 4'd4, '0, '0, 1'b1);
      #1;
      checkOutput("grant_busy", 32'(aluBusy), 32'd0);
      tick();
      idle(1'b1);
      checkOutput("replace_wbEn", 32'(wbEn), 32'd1);
      checkOutput("replace_wbTag", 32'(wbTag), 32'd4);
      checkOutput("replace_wbData", wbData, 32'd11);
      checkOutput("replace_protErr", 32'(protErr), 32'd0);
      tick();

      // Misprediction kills a held entry that depends on branch 1
      applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, 4'd6, '0, 4'b0010, 1'b0);
      tick();
      idle(1'b0);
      setBranch(1'b1, 1'b1, 2'd1);
      #1;
      checkOutput("kill_visible", 32'(wbEn), 32'd1);
      tick();
      setBranch(1'b0, 1'b0, 2'd0);
      checkOutput("kill_wbEn", 32'(wbEn), 32'd0);

      // Mispredicting an unrelated branch leaves the entry alone
      applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, 4'd6, '0, 4'b0010, 1'b0);
      tick();
      idle(1'b0);
      setBranch(1'b1, 1'b1, 2'd0);
      tick();
      setBranch(1'b0, 1'b0, 2'd0);
      checkOutput("nokill_wbEn", 32'(wbEn), 32'd1);
      checkOutput("nokill_wbBTag", 32'(wbBTag), 32'b0010);
      idle(1'b1);
      tick();

      // Correct prediction clears the bit and keeps the entry
      applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, 4'd7, '0, 4'b0010, 1'b0);
      tick();
      idle(1'b0);
      setBranch(1'b1, 1'b0, 2'd1);
      tick();
      setBranch(1'b0, 1'b0, 2'd0);
      checkOutput("resolve_wbEn", 32'(wbEn), 32'd1);
      checkOutput("resolve_wbTag", 32'(wbTag), 32'd7);
      checkOutput("resolve_wbBTag", 32'(wbBTag), 32'd0);
      idle(1'b1);
      tick();

      // An incoming op on a mispredicted branch is never loaded
      applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, 4'd8, '0, 4'b0100, 1'b1);
      setBranch(1'b1, 1'b1, 2'd2);
      tick();
      setBranch(1'b0, 1'b0, 2'd0);
      idle(1'b1);
      checkOutput("killin_wbEn", 32'(wbEn), 32'd0);

      // An incoming op on a resolved branch is captured with the bit cleared
      applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, 4'd8, '0, 4'b1100, 1'b1);
      setBranch(1'b1, 1'b0, 2'd2);
      tick();
      setBranch(1'b0, 1'b0, 2'd0);
      idle(1'b1);
      checkOutput("resolvein_wbEn", 32'(wbEn), 32'd1);
      checkOutput("resolvein_wbBTag", 32'(wbBTag), 32'b1000);
      tick();

      // Issue while busy is dropped and latches protErr until reset
      applyStimulus(1'b1, OP_ADD, 32'd4, 32'd4, 4'd8, '0, '0, 1'b0);
      tick();
      applyStimulus(1'b1, OP_ADD, 32'd9, 32'd9, 4'd9, '0, '0, 1'b0);
      tick();
      idle(1'b0);
      checkOutput("prot_err", 32'(protErr), 32'd1);
      checkOutput("prot_keepTag", 32'(wbTag), 32'd8);
      checkOutput("prot_keepData", wbData, 32'd8);
      idle(1'b1);
      tick();
      checkOutput("prot_sticky", 32'(protErr), 32'd1);
      applyStimulus(1'b1, OP_ADD, 32'd1, 32'd2, 4'd10, '0, '0, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle(1'b0);
      checkOutput("rst2_wbEn", 32'(wbEn), 32'd0);
      checkOutput("rst2_wbTag", 32'(wbTag), 32'd0);
      checkOutput("rst2_wbData", wbData, 32'd0);
      checkOutput("rst2_protErr", 32'(protErr), 32'd0);

      // Back-to-back stream with the bus granting every cycle
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, OP_ADD, DataBus'(i), 32'd100, TagBus'(i + 1), '0, '0, 1'b1);
         tick();
         checkOutput("stream_wbEn", 32'(wbEn), 32'd1);
         checkOutput("stream_wbTag", 32'(wbTag), 32'(i + 1));
         checkOutput("stream_wbData", wbData, 32'(i + 100));
      end
      idle(1'b1);
      tick();
      checkOutput("stream_end", 32'(wbEn), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
